// File: rtl/io_pkg.sv
// Shared defaults and types for the buffered CPU/host I/O port.
package io_pkg;
    localparam int IO_WIDTH = 64;
    localparam int IO_DEPTH = 16;

    typedef logic [$clog2(IO_DEPTH+1)-1:0] count_t;
endpackage

// File: rtl/io_port_ctrl_if.sv
// CPU strobe/data and host valid/ready bundle around io_port_ctrl.
interface io_port_ctrl_if
    import io_pkg::*;
#(
    parameter int WIDTH = IO_WIDTH,
    parameter int DEPTH = IO_DEPTH
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic             cpu_in_signal;
    logic [WIDTH-1:0] cpu_in_data;
    logic             cpu_out_signal;
    logic [WIDTH-1:0] cpu_out_data;
    logic             host_rx_valid;
    logic             host_rx_ready;
    logic [WIDTH-1:0] host_rx_data;
    logic             host_tx_valid;
    logic             host_tx_ready;
    logic [WIDTH-1:0] host_tx_data;
    logic [CW-1:0]    rx_count;
    logic [CW-1:0]    tx_count;
    logic             io_error;
    logic             err_clear;

    // The port controller itself.
    modport slave (
        input  cpu_in_signal, cpu_out_signal, cpu_out_data,
        input  host_rx_valid, host_rx_data, host_tx_ready, err_clear,
        output cpu_in_data, host_rx_ready, host_tx_valid, host_tx_data,
        output rx_count, tx_count, io_error
    );

    // The CPU core plus host side driving the controller.
    modport master (
        output cpu_in_signal, cpu_out_signal, cpu_out_data,
        output host_rx_valid, host_rx_data, host_tx_ready, err_clear,
        input  cpu_in_data, host_rx_ready, host_tx_valid, host_tx_data,
        input  rx_count, tx_count, io_error
    );
endinterface

// File: rtl/io_port_ctrl_sync_fifo.sv
// Single-clock FIFO with separate occupancy count; head is read combinationally.
module sync_fifo
    import io_pkg::*;
#(
    parameter int WIDTH = IO_WIDTH,
    parameter int DEPTH = IO_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             pop_ok;
    logic             push_ok;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign head  = mem[rd_ptr];

    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/io_port_ctrl.sv
// Buffered I/O port: host->CPU RX FIFO and CPU->host TX FIFO with a sticky error flag.
module io_port_ctrl
    import io_pkg::*;
#(
    parameter int WIDTH = IO_WIDTH,
    parameter int DEPTH = IO_DEPTH
) (
    input logic           clk,
    input logic           reset,
    io_port_ctrl_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] rx_head;
    logic [WIDTH-1:0] tx_head;
    logic             rx_full;
    logic             rx_empty;
    logic             tx_full;
    logic             tx_empty;
    logic [CW-1:0]    rx_cnt;
    logic [CW-1:0]    tx_cnt;
    logic             rx_push;
    logic             rx_underflow;
    logic             tx_overflow;
    logic             err;

    // The host only transfers while ready is high, so gate the push on not-full.
    assign rx_push = bus.host_rx_valid && !rx_full;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (bus.host_rx_data),
        .pop       (bus.cpu_in_signal),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_cnt)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.cpu_out_signal),
        .push_data (bus.cpu_out_data),
        .pop       (bus.host_tx_ready),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_cnt)
    );

    assign bus.cpu_in_data   = rx_empty ? '0 : rx_head;
    assign bus.host_tx_data  = tx_empty ? '0 : tx_head;
    assign bus.host_rx_ready = !rx_full;
    assign bus.host_tx_valid = !tx_empty;
    assign bus.rx_count      = rx_cnt;
    assign bus.tx_count      = tx_cnt;
    assign bus.io_error      = err;

    // A full TX with the host draining in the same cycle is not an overflow.
    assign rx_underflow = bus.cpu_in_signal && rx_empty;
    assign tx_overflow  = bus.cpu_out_signal && tx_full && !bus.host_tx_ready;

    always_ff @(posedge clk) begin
        if (reset)                            err <= 1'b0;
        else if (rx_underflow || tx_overflow) err <= 1'b1;
        else if (bus.err_clear)               err <= 1'b0;
    end
endmodule

// File: tb/tb_io_port_ctrl.sv
// Randomized and directed checks of io_port_ctrl against a queue-based reference model.
module tb_io_port_ctrl;
    import io_pkg::*;

    localparam int W = IO_WIDTH;
    localparam int D = IO_DEPTH;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    io_port_ctrl_if #(.WIDTH(W), .DEPTH(D)) bus ();

    io_port_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] rx_q[$];
    logic [W-1:0] tx_q[$];
    bit           m_err;

    // Reference: apply one clock edge to the queues using the currently driven inputs.
    task automatic model_edge();
        bit rx_pop, rx_under, rx_push, tx_pop, tx_push, tx_over;
        if (reset) begin
            rx_q.delete();
            tx_q.delete();
            m_err = 1'b0;
            return;
        end
        rx_pop   = bus.cpu_in_signal && rx_q.size() > 0;
        rx_under = bus.cpu_in_signal && rx_q.size() == 0;
        rx_push  = bus.host_rx_valid && rx_q.size() < D;
        tx_pop   = bus.host_tx_ready && tx_q.size() > 0;
        tx_push  = bus.cpu_out_signal && (tx_q.size() < D || tx_pop);
        tx_over  = bus.cpu_out_signal && !tx_push;
        if (rx_pop)  void'(rx_q.pop_front());
        if (rx_push) rx_q.push_back(bus.host_rx_data);
        if (tx_pop)  void'(tx_q.pop_front());
        if (tx_push) tx_q.push_back(bus.cpu_out_data);
        if (rx_under || tx_over) m_err = 1'b1;
        else if (bus.err_clear)  m_err = 1'b0;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_in_signal  = 1'b0;
        bus.cpu_out_signal = 1'b0;
        bus.cpu_out_data   = '0;
        bus.host_rx_valid  = 1'b0;
        bus.host_rx_data   = '0;
        bus.host_tx_ready  = 1'b0;
        bus.err_clear      = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        n_tests++;
        if (bus.host_rx_ready !== 1'b1 || bus.host_tx_valid !== 1'b0 ||
            bus.rx_count !== '0 || bus.tx_count !== '0 ||
            bus.cpu_in_data !== '0 || bus.host_tx_data !== '0 || bus.io_error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b rxc=%0d txc=%0d in=%h tx=%h err=%b, want 1 0 0 0 0 0 0",
                     bus.host_rx_ready, bus.host_tx_valid, bus.rx_count, bus.tx_count,
                     bus.cpu_in_data, bus.host_tx_data, bus.io_error);
        end
    endtask

    task automatic test_rx_basic();
        bus.host_rx_valid = 1'b1;
        bus.host_rx_data  = 64'hA;
        cycle();
        n_tests++;
        if (bus.cpu_in_data !== 64'hA) begin
            n_fail++;
            $display("FAIL rx_latency: cpu_in_data=%h want a", bus.cpu_in_data);
        end
        bus.host_rx_data = 64'hB;
        cycle();
        bus.host_rx_valid = 1'b0;
        n_tests++;
        if (bus.rx_count !== count_t'(2) || bus.cpu_in_data !== 64'hA) begin
            n_fail++;
            $display("FAIL rx_two_words: rx_count=%0d in=%h want 2 a", bus.rx_count, bus.cpu_in_data);
        end
        bus.cpu_in_signal = 1'b1;
        cycle();
        bus.cpu_in_signal = 1'b0;
        n_tests++;
        if (bus.cpu_in_data !== 64'hB || bus.rx_count !== count_t'(1)) begin
            n_fail++;
            $display("FAIL rx_pop1: in=%h rx_count=%0d want b 1", bus.cpu_in_data, bus.rx_count);
        end
        bus.cpu_in_signal = 1'b1;
        cycle();
        bus.cpu_in_signal = 1'b0;
        n_tests++;
        if (bus.rx_count !== '0 || bus.cpu_in_data !== '0 || bus.io_error !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_pop2: rx_count=%0d in=%h err=%b want 0 0 0",
                     bus.rx_count, bus.cpu_in_data, bus.io_error);
        end
    endtask

    task automatic test_underflow();
        bus.cpu_in_signal = 1'b1;
        cycle();
        bus.cpu_in_signal = 1'b0;
        n_tests++;
        if (bus.io_error !== 1'b1 || bus.cpu_in_data !== '0 || bus.rx_count !== '0) begin
            n_fail++;
            $display("FAIL rx_underflow: err=%b in=%h rx_count=%0d want 1 0 0",
                     bus.io_error, bus.cpu_in_data, bus.rx_count);
        end
        // Set wins over clear in the same cycle.
        bus.cpu_in_signal = 1'b1;
        bus.err_clear     = 1'b1;
        cycle();
        bus.cpu_in_signal = 1'b0;
        n_tests++;
        if (bus.io_error !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set_priority: err=%b want 1", bus.io_error);
        end
        cycle();
        bus.err_clear = 1'b0;
        n_tests++;
        if (bus.io_error !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: err=%b want 0", bus.io_error);
        end
    endtask

    task automatic test_tx_overflow();
        bus.host_tx_ready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            bus.cpu_out_signal = 1'b1;
            bus.cpu_out_data   = W'(i);
            cycle();
        end
        bus.cpu_out_signal = 1'b0;
        n_tests++;
        if (bus.tx_count !== count_t'(16) || bus.io_error !== 1'b1 || bus.host_tx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_overflow: tx_count=%0d err=%b vld=%b want 16 1 1",
                     bus.tx_count, bus.io_error, bus.host_tx_valid);
        end
        bus.host_tx_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            n_tests++;
            if (bus.host_tx_valid !== 1'b1 || bus.host_tx_data !== W'(i)) begin
                n_fail++;
                $display("FAIL tx_drain[%0d]: vld=%b data=%h want 1 %h", i,
                         bus.host_tx_valid, bus.host_tx_data, W'(i));
            end
            cycle();
        end
        bus.host_tx_ready = 1'b0;
        n_tests++;
        if (bus.host_tx_valid !== 1'b0 || bus.tx_count !== '0 || bus.host_tx_data !== '0) begin
            n_fail++;
            $display("FAIL tx_drained: vld=%b tx_count=%0d data=%h want 0 0 0",
                     bus.host_tx_valid, bus.tx_count, bus.host_tx_data);
        end
        bus.err_clear = 1'b1;
        cycle();
        bus.err_clear = 1'b0;
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) begin
            bus.cpu_out_signal = 1'b1;
            bus.cpu_out_data   = W'(64'h100 + i);
            cycle();
        end
        bus.cpu_out_data  = 64'h55;
        bus.host_tx_ready = 1'b1;
        cycle();
        bus.cpu_out_signal = 1'b0;
        bus.host_tx_ready  = 1'b0;
        n_tests++;
        if (bus.tx_count !== count_t'(16) || bus.io_error !== 1'b0 || bus.host_tx_data !== 64'h101) begin
            n_fail++;
            $display("FAIL tx_full_push_pop: tx_count=%0d err=%b head=%h want 16 0 101",
                     bus.tx_count, bus.io_error, bus.host_tx_data);
        end
        bus.host_tx_ready = 1'b1;
        for (int i = 0; i < 15; i++) cycle();
        n_tests++;
        if (bus.host_tx_data !== 64'h55 || bus.tx_count !== count_t'(1)) begin
            n_fail++;
            $display("FAIL tx_last_word: data=%h tx_count=%0d want 55 1", bus.host_tx_data, bus.tx_count);
        end
        cycle();
        bus.host_tx_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.host_rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.host_rx_data = W'(64'h200 + i);
            cycle();
        end
        reset = 1'b1;
        bus.host_rx_data = 64'hDEAD;
        cycle();
        reset = 1'b0;
        bus.host_rx_valid = 1'b0;
        n_tests++;
        if (bus.rx_count !== '0 || bus.cpu_in_data !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: rx_count=%0d in=%h want 0 0", bus.rx_count, bus.cpu_in_data);
        end
        bus.host_rx_valid = 1'b1;
        bus.host_rx_data  = 64'h77;
        cycle();
        bus.host_rx_valid = 1'b0;
        n_tests++;
        if (bus.cpu_in_data !== 64'h77 || bus.rx_count !== count_t'(1)) begin
            n_fail++;
            $display("FAIL reset_mid_push: in=%h rx_count=%0d want 77 1", bus.cpu_in_data, bus.rx_count);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_in, exp_tx;
        for (int i = 0; i < 1500; i++) begin
            // Phases alternate between filling and draining so both full and empty are hit.
            int ph = (i / 100) % 3;
            bus.host_rx_valid  = ($urandom_range(0, 3) < (ph == 0 ? 3 : 1));
            bus.host_rx_data   = {$urandom, $urandom};
            bus.cpu_in_signal  = ($urandom_range(0, 3) < (ph == 0 ? 1 : 2));
            bus.cpu_out_signal = ($urandom_range(0, 3) < (ph == 1 ? 3 : 1));
            bus.cpu_out_data   = {$urandom, $urandom};
            bus.host_tx_ready  = ($urandom_range(0, 3) < (ph == 1 ? 1 : 3));
            bus.err_clear      = ($urandom_range(0, 9) == 0);
            reset              = ($urandom_range(0, 199) == 0);
            exp_in = (rx_q.size() > 0) ? rx_q[0] : '0;
            exp_tx = (tx_q.size() > 0) ? tx_q[0] : '0;
            n_tests++;
            if (bus.rx_count !== count_t'(rx_q.size()) || bus.tx_count !== count_t'(tx_q.size())) begin
                n_fail++;
                $display("FAIL rand_count[%0d]: rx=%0d tx=%0d want %0d %0d", i,
                         bus.rx_count, bus.tx_count, rx_q.size(), tx_q.size());
            end
            n_tests++;
            if (bus.cpu_in_data !== exp_in || bus.host_tx_data !== exp_tx) begin
                n_fail++;
                $display("FAIL rand_data[%0d]: in=%h tx=%h want %h %h", i,
                         bus.cpu_in_data, bus.host_tx_data, exp_in, exp_tx);
            end
            n_tests++;
            if (bus.host_rx_ready !== (rx_q.size() < D) || bus.host_tx_valid !== (tx_q.size() > 0) ||
                bus.io_error !== m_err) begin
                n_fail++;
                $display("FAIL rand_flags[%0d]: rdy=%b vld=%b err=%b want %b %b %b", i,
                         bus.host_rx_ready, bus.host_tx_valid, bus.io_error,
                         rx_q.size() < D, tx_q.size() > 0, m_err);
            end
            cycle();
        end
        reset = 1'b0;
        idle_inputs();
        cycle();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_rx_basic();
        test_underflow();
        test_tx_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
